// File: rtl/int_gateway_bank.sv
// Interrupt gateway bank: per-source level/edge gateways with a fixed
// lowest-index-wins priority, a claim/complete handshake and edge backlog.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low
//   int_in         per-source interrupt levels, already synchronous
//   claim_req      one-cycle claim strobe from the target
//   complete_valid completion strobe
//   complete_id    ID being completed (source i carries ID i+1)
//   irq_out        any source pending
//   irq_id         lowest-index pending ID, 0 if none
//   claim_valid    one-cycle response to claim_req
//   claim_id       claimed ID, 0 when nothing was pending
module int_gateway_bank #(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
    parameter int                 CNT_W     = 2,
    localparam int                IDW       = $clog2(NUM_SRC + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] int_in,
    input  logic               claim_req,
    input  logic               complete_valid,
    input  logic [IDW-1:0]     complete_id,
    output logic               irq_out,
    output logic [IDW-1:0]     irq_id,
    output logic               claim_valid,
    output logic [IDW-1:0]     claim_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_INFLIGHT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q [NUM_SRC];
    state_t             state_d [NUM_SRC];
    logic [CNT_W-1:0]   cnt_q   [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d   [NUM_SRC];
    logic [NUM_SRC-1:0] prev_q;
    logic               claim_valid_q;
    logic [IDW-1:0]     claim_id_q;
    logic [IDW-1:0]     irq_id_c;

    // Scan from the top so the lowest pending index is written last.
    always_comb begin
        irq_id_c = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (state_q[i] == S_PENDING) begin
                irq_id_c = IDW'(i + 1);
            end
        end
    end

    assign irq_out     = (irq_id_c != '0);
    assign irq_id      = irq_id_c;
    assign claim_valid = claim_valid_q;
    assign claim_id    = claim_id_q;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            unique case (state_q[i])
                S_IDLE: begin
                    if (!EDGE_MASK[i] && int_in[i]) begin
                        state_d[i] = S_PENDING;
                    end
                end
                S_PENDING: begin
                    // Only the source currently shown on irq_id is claimed.
                    if (claim_req && irq_id_c == IDW'(i + 1)) begin
                        state_d[i] = S_INFLIGHT;
                    end
                end
                S_INFLIGHT: begin
                    if (complete_valid && complete_id == IDW'(i + 1)) begin
                        if (EDGE_MASK[i] && cnt_q[i] != '0) begin
                            state_d[i] = S_PENDING;
                            cnt_d[i]   = cnt_q[i] - CNT_W'(1);
                        end else begin
                            state_d[i] = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase

            // An edge is applied on top of the claim/complete transition
            // so it is never lost: it re-pends an idle source, otherwise
            // it joins the saturating backlog.
            if (EDGE_MASK[i] && int_in[i] && !prev_q[i]) begin
                if (state_d[i] == S_IDLE) begin
                    state_d[i] = S_PENDING;
                end else if (cnt_d[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_d[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            prev_q        <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            prev_q        <= int_in;
            claim_valid_q <= claim_req;
            claim_id_q    <= claim_req ? irq_id_c : '0;
        end
    end

endmodule

// File: tb/tb_int_gateway_bank.sv
// Directed bench for int_gateway_bank: source 0 edge, sources 1-3 level.
// Claim responses are scored from a queue by an independent monitor.
module tb_int_gateway_bank;

    localparam int NUM_SRC = 4;
    localparam int IDW     = 3;

    logic               clock;
    logic               reset;
    logic [NUM_SRC-1:0] int_in;
    logic               claim_req;
    logic               complete_valid;
    logic [IDW-1:0]     complete_id;
    logic               irq_out;
    logic [IDW-1:0]     irq_id;
    logic               claim_valid;
    logic [IDW-1:0]     claim_id;

    int errors = 0;
    int checks = 0;
    logic [IDW-1:0] exp_q [$];

    int_gateway_bank #(
        .NUM_SRC   (NUM_SRC),
        .EDGE_MASK (4'b0001),
        .CNT_W     (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .int_in         (int_in),
        .claim_req      (claim_req),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .irq_out        (irq_out),
        .irq_id         (irq_id),
        .claim_valid    (claim_valid),
        .claim_id       (claim_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (claim_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL claim_spurious: got claim_id=%0d, required no claim",
                         claim_id);
            end else begin
                logic [IDW-1:0] e;
                e = exp_q.pop_front();
                if (claim_id !== e) begin
                    errors++;
                    $display("FAIL claim_id: got %0d, required %0d", claim_id, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic chk_irq(input string name, input int o, input int id);
        chk({name, "_out"}, int'(irq_out), o);
        chk({name, "_id"}, int'(irq_id), id);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic claim(input logic [IDW-1:0] exp_id);
        exp_q.push_back(exp_id);
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
    endtask

    task automatic complete(input logic [IDW-1:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        step();
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    task automatic pulse0();
        int_in[0] = 1'b1;
        step();
        int_in[0] = 1'b0;
        step();
    endtask

    initial begin
        reset          = 1'b0;
        int_in         = '0;
        claim_req      = 1'b0;
        complete_valid = 1'b0;
        complete_id    = '0;
        step();
        step();
        chk_irq("reset", 0, 0);
        chk("reset_cv", int'(claim_valid), 0);
        chk("reset_cid", int'(claim_id), 0);
        reset = 1'b1;
        step();

        // Level source 3 pends, is claimed, completes and re-pends.
        int_in = 4'b0100;
        step();
        chk_irq("lvl_pend", 1, 3);
        claim(3);
        chk_irq("lvl_inflight", 0, 0);
        complete(3);
        chk_irq("lvl_done", 0, 0);
        step();
        chk_irq("lvl_repend", 1, 3);
        int_in = '0;
        claim(3);
        complete(3);
        step();
        chk_irq("lvl_clean", 0, 0);

        // Priority with back-to-back claims, then an empty claim.
        int_in = 4'b1010;
        step();
        chk_irq("prio", 1, 2);
        claim(2);
        claim(4);
        claim(0);
        chk_irq("prio_none", 0, 0);
        int_in = '0;
        complete(2);
        complete(4);
        step();
        chk_irq("prio_clean", 0, 0);

        // Edge backlog: 5 pulses saturate at 3 extra.
        for (int k = 0; k < 5; k++) pulse0();
        chk_irq("edge_pend", 1, 1);
        for (int k = 0; k < 4; k++) begin
            claim(1);
            complete(1);
        end
        chk_irq("edge_drained", 0, 0);
        claim(0);

        // Edge on the claim cycle is counted.
        pulse0();
        int_in[0] = 1'b1;
        claim(1);
        int_in[0] = 1'b0;
        complete(1);
        chk_irq("edge_on_claim", 1, 1);
        claim(1);
        complete(1);
        chk_irq("edge_on_claim_done", 0, 0);

        // Bogus completions leave everything untouched.
        int_in = 4'b0110;
        step();
        claim(2);
        chk_irq("bogus_setup", 1, 3);
        complete(0);
        chk_irq("bogus_id0", 1, 3);
        complete(7);
        chk_irq("bogus_id7", 1, 3);
        complete(3);
        chk_irq("bogus_pend", 1, 3);
        claim(3);
        int_in = '0;
        complete(2);
        complete(3);
        step();
        chk_irq("bogus_clean", 0, 0);

        // Same-cycle claim of source 1 and completion of source 2.
        int_in = 4'b0010;
        step();
        claim(2);
        int_in = 4'b0011;
        step();
        int_in = 4'b0010;
        chk_irq("same_setup", 1, 1);
        exp_q.push_back(1);
        claim_req      = 1'b1;
        complete_valid = 1'b1;
        complete_id    = 2;
        step();
        claim_req      = 1'b0;
        complete_valid = 1'b0;
        complete_id    = '0;
        chk_irq("same_after", 0, 0);
        step();
        chk_irq("same_repend", 1, 2);
        int_in = '0;
        claim(2);
        complete(2);
        complete(1);
        step();
        chk_irq("same_clean", 0, 0);

        // Reset while source 1 is in flight with backlog 2.
        for (int k = 0; k < 3; k++) pulse0();
        claim(1);
        step();
        chk_irq("rst_setup", 0, 0);
        int_in = 4'b0001;
        reset  = 1'b0;
        #1;
        chk_irq("rst_mid", 0, 0);
        chk("rst_mid_cv", int'(claim_valid), 0);
        step();
        reset = 1'b1;
        chk_irq("rst_release", 0, 0);
        step();
        chk_irq("rst_edge", 1, 1);
        complete(1);
        chk_irq("rst_stale", 1, 1);
        claim(1);
        int_in = '0;
        complete(1);
        step();
        chk_irq("rst_clean", 0, 0);

        step();
        step();
        chk("claims_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
